// File: rtl/kaliski_almost_inv_ctrl_if.sv
// Start/done handshake and operand/result bus of the almost-inverse sequencer.
interface kaliski_almost_inv_ctrl_if #(
  parameter int unsigned W  = 32,
  parameter int unsigned KW = 7
);
  logic          start;
  logic [W-1:0]  a_in;
  logic [W-1:0]  p_in;
  logic          busy;
  logic          done;
  logic          err;
  logic [W-1:0]  res;
  logic [KW-1:0] k;

  // Requester side (top-level inverter FSM or bench).
  modport master (
    output start, a_in, p_in,
    input  busy, done, err, res, k
  );

  // Sequencer side.
  modport slave (
    input  start, a_in, p_in,
    output busy, done, err, res, k
  );
endinterface

// File: rtl/kaliski_almost_inv_ctrl.sv
// Phase 1 of the Kaliski Montgomery inverse: iterates the almost-inverse loop one step per clock
// and returns x = a^-1 * 2^k mod p together with k.
module kaliski_almost_inv_ctrl #(
  parameter int unsigned W  = 32,
  parameter int unsigned KW = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  kaliski_almost_inv_ctrl_if.slave   bus_io
);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StLoop,
    StCorrect,
    StFinal,
    StDone
  } state_e;

  localparam logic [KW-1:0] KMax = KW'(2 * W);

  state_e        state_q, state_d;
  logic [W-1:0]  u_q, u_d;
  logic [W-1:0]  v_q, v_d;
  logic [W:0]    r_q, r_d;
  logic [W:0]    s_q, s_d;
  logic [W-1:0]  p_q, p_d;
  logic [KW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  res_q, res_d;
  logic [KW-1:0] k_q, k_d;
  logic          err_q, err_d;

  // Magnitude comparisons; in CHECK, v still holds the captured operand a.
  logic u_gt_v, a_ge_p, r_ge_p;
  assign u_gt_v = (u_q > v_q);
  assign a_ge_p = (v_q >= p_q);
  assign r_ge_p = r_q[W] | (r_q[W-1:0] >= p_q);

  // Next-state and datapath updates for each sequencer state.
  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    r_d     = r_q;
    s_d     = s_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    k_d     = k_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          u_d     = bus_io.p_in;
          v_d     = bus_io.a_in;
          r_d     = '0;
          s_d     = (W+1)'(1);
          cnt_d   = '0;
          p_d     = bus_io.p_in;
          state_d = StCheck;
        end
      end
      StCheck: begin
        res_d = '0;
        k_d   = '0;
        err_d = (v_q == '0) | ~p_q[0] | a_ge_p;
        state_d = ((v_q == '0) | ~p_q[0] | a_ge_p) ? StDone : StLoop;
      end
      StLoop: begin
        if (v_q == '0) begin
          state_d = StCorrect;
        end else if (cnt_q == KMax) begin
          // Another step would push k past 2W; only reachable with bad inputs.
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + KW'(1);
          if (!u_q[0]) begin
            u_d = u_q >> 1;
            s_d = {s_q[W-1:0], 1'b0};
          end else if (!v_q[0]) begin
            v_d = v_q >> 1;
            r_d = {r_q[W-1:0], 1'b0};
          end else if (u_gt_v) begin
            u_d = (u_q - v_q) >> 1;
            r_d = r_q + s_q;
            s_d = {s_q[W-1:0], 1'b0};
          end else begin
            v_d = (v_q - u_q) >> 1;
            s_d = s_q + r_q;
            r_d = {r_q[W-1:0], 1'b0};
          end
        end
      end
      StCorrect: begin
        if (r_ge_p) begin
          r_d = r_q - {1'b0, p_q};
        end
        state_d = StFinal;
      end
      StFinal: begin
        res_d   = p_q - r_q[W-1:0];
        k_d     = cnt_q;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      u_q     <= '0;
      v_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      r_q     <= r_d;
      s_q     <= s_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  // Handshake outputs decode directly from the registered state.
  always_comb begin
    bus_io.busy = (state_q != StIdle) && (state_q != StDone);
    bus_io.done = (state_q == StDone);
    bus_io.err  = err_q;
    bus_io.res  = res_q;
    bus_io.k    = k_q;
  end

endmodule

// File: doc/kaliski_almost_inv_ctrl.md
Name: kaliski_almost_inv_ctrl

Overview:
- Sequencer for phase 1 of the Kaliski Montgomery inverse (the almost-inverse loop).
- Given odd modulus p and operand a with 0 < a < p, returns x = a^-1 * 2^k mod p and iteration count k.
- One loop iteration per clock; the u-vs-v decision and range checks use compare_32bit instances.
- Feeds the phase-2 correction block. Start/done handshake to the top-level inverter FSM.

Parameters:
- W, 32, operand width. Fixed at 32 because compare_32bit is 32-bit.
- KW, 7, width of k. Equals clog2(2*W+1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a_in  in  W  operand a
- p_in  in  W  modulus p
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; res/k/err valid from this cycle on
- err  out  1  invalid input or iteration overflow; held with result
- res  out  W  x = p - r (r already reduced mod p)
- k  out  KW  iteration count

Behaviour:
- Interface decision: one clock clk; reset rst is synchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, err=0, res=0, k=0; internal u,v,r,s cleared.
- Reset asserted mid-operation aborts the computation. No done pulse is produced.
- Internal registers: u, v are W bits; r, s are W+1 bits (r, s < 2p). The k counter is KW bits.
- Operands a_in and p_in are captured at start. Later input changes are ignored.

State machine:
- IDLE: on start=1, load u=p_in, v=a_in, r=0, s=1, k=0, latch p. Go to CHECK; busy=1 from the next cycle.
- start while busy is ignored.
- CHECK: err condition is a==0, or p[0]==0, or a>=p (from the comparator). If err, go to DONE with err=1, res=0, k=0. Otherwise go to LOOP.
- LOOP, when v==0: go to CORRECT with no update.
- LOOP, otherwise, one update per cycle with k=k+1. Conditions are evaluated in priority order:
  - u even: u=u>>1, s=s<<1.
  - else v even: v=v>>1, r=r<<1.
  - else u>v (compare_32bit gt): u=(u-v)>>1, r=r+s, s=s<<1.
  - else (u<=v): v=(v-u)>>1, s=s+r, r=r<<1.
- LOOP overflow: if k would exceed 2W, go to DONE with err=1. This is unreachable for valid inputs.
- CORRECT: if r>=p (r[W] | ~lt from compare_32bit(r[W-1:0], p)), then r=r-p. Go to FINAL.
- FINAL: res=p-r[W-1:0], k output = k counter. Go to DONE.
- DONE: done=1 for exactly one cycle, busy=0. Return to IDLE. A start in this cycle is ignored.
- res/err/k hold their values until the next accepted start; they are cleared in CHECK of the new run.

Latency:
- Start sampled at edge E.
- Valid input: done high in the cycle after edge E+k+4.
- Error: done high in the cycle after edge E+1.

Arithmetic:
- Subtractions u-v and v-u are non-negative by construction.
- r+s never exceeds 2p, so it fits in W+1 bits with no wrap.
- u and v never increase.

Test Plan:
- a=3, p=7: start one cycle -> done 8 cycles after start edge; res=3, k=4, err=0. Trace (u,v,r,s) per iteration: (2,3,1,2), (1,3,1,4), (1,1,2,5), (1,0,4,7).
- a=1, p=7 -> res=1, k=3, err=0, done after 7 cycles.
- Invalid inputs: a=0 p=7; a=7 p=7; a=9 p=7; a=3 p=8 -> each gives done 2 cycles after start, err=1, res=0, k=0.
- a=0xFFFFFFFD, p=0xFFFFFFFF, plus 1000 random valid pairs. Check res == a^-1*2^k mod p against the model, and 32<=k<=64, done latency k+4, busy high throughout.
- Start held high continuously during a run -> single run only; a new run starts only from IDLE after done.
- Assert rst at the 3rd LOOP cycle -> next cycle busy=0, done=0, res=0, k=0. A subsequent start with a=3, p=7 gives the correct res=3, k=4.
